// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision field layout and converter state encoding.
package float_pkg;

  localparam int unsigned FLOAT_EXP_BIAS = 127;
  localparam int unsigned FLOAT_EXP_W    = 8;
  localparam int unsigned FLOAT_FRAC_W   = 23;

  typedef struct packed {
    logic                    sign;
    logic [FLOAT_EXP_W-1:0]  exponent;
    logic [FLOAT_FRAC_W-1:0] fraction;
  } float_fields_t;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } conv_state_t;

endpackage

// File: rtl/iterated_float_to_fixed.sv
// Float-to-signed-integer converter: trivial cases resolve in one cycle,
// normal values shift fraction bits into the magnitude one per cycle.
module iterated_float_to_fixed
  import float_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  output logic             done,
  input  logic [31:0]      float,
  output logic [WIDTH-1:0] fixed,
  output logic             ovf
);

  localparam int unsigned MAG_W = WIDTH - 1;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [8:0]  E_MAX = 9'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  conv_state_t             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MAG_W-1:0]        mag_q, mag_d;
  logic [FLOAT_FRAC_W-1:0] frac_q, frac_d;
  logic                    sign_q, sign_d;
  logic                    min_q, min_d;
  logic                    ovf_q, ovf_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;

  float_fields_t           fields;
  logic [8:0]              e_unb;
  logic                    is_special;
  logic                    is_zero;
  logic                    is_sat;
  logic                    is_exact_min;
  logic [WIDTH-1:0]        mag_ext;

  // Operand classification.
  always_comb begin
    fields       = float_fields_t'(float);
    e_unb        = 9'(fields.exponent) - 9'(FLOAT_EXP_BIAS);
    is_special   = (fields.exponent == '1);
    is_zero      = !is_special && (fields.exponent < FLOAT_EXP_W'(FLOAT_EXP_BIAS));
    is_exact_min = !is_special && !is_zero && (e_unb == E_MAX) &&
                   fields.sign && (fields.fraction == '0);
    is_sat       = is_special ||
                   (!is_zero && (e_unb >= E_MAX) && !is_exact_min);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    frac_d  = frac_q;
    sign_d  = sign_q;
    min_d   = min_q;
    ovf_d   = ovf_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && ready_q) begin
          sign_d = fields.sign;
          min_d  = 1'b0;
          ovf_d  = 1'b0;
          mag_d  = '0;
          frac_d = '0;
          cnt_d  = '0;
          if (is_sat) begin
            // Positive non-NaN saturates high; everything else to the minimum.
            ovf_d = 1'b1;
            if (!fields.sign && !(is_special && fields.fraction != '0)) begin
              sign_d = 1'b0;
              mag_d  = '1;
            end else begin
              min_d = 1'b1;
            end
            done_d = 1'b1;
          end else if (is_zero) begin
            sign_d = 1'b0;
            done_d = 1'b1;
          end else if (is_exact_min) begin
            min_d  = 1'b1;
            done_d = 1'b1;
          end else if (e_unb == 9'd0) begin
            mag_d  = MAG_W'(1);
            done_d = 1'b1;
          end else begin
            mag_d   = MAG_W'(1);
            frac_d  = fields.fraction;
            cnt_d   = CNT_W'(e_unb);
            ready_d = 1'b0;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        mag_d  = (mag_q << 1) | MAG_W'(frac_q[FLOAT_FRAC_W-1]);
        frac_d = frac_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      frac_q  <= '0;
      sign_q  <= 1'b0;
      min_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      frac_q  <= frac_d;
      sign_q  <= sign_d;
      min_q   <= min_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Result is formed from held registers so it stays stable until the next start.
  assign mag_ext = WIDTH'(mag_q);
  assign fixed   = min_q ? MIN_VAL : (sign_q ? -mag_ext : mag_ext);
  assign ovf     = ovf_q;
  assign ready   = ready_q;
  assign done    = done_q;

endmodule

// File: tb/tb_iterated_float_to_fixed.sv
// Scoreboard bench for iterated_float_to_fixed at WIDTH=8.
module tb_iterated_float_to_fixed;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      float_in = 32'h0;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] fixed;
  logic             ovf;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] op;
    logic [7:0]  fx;
    logic        ov;
    int          cy;
  } exp_t;

  exp_t sb[$];

  iterated_float_to_fixed #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ready (ready),
    .done  (done),
    .float (float_in),
    .fixed (fixed),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got fixed=%h ovf=%b at cyc=%0d, required no done", fixed, ovf, cyc);
      end else begin
        e = sb.pop_front();
        if (fixed !== e.fx || ovf !== e.ov || cyc != e.cy) begin
          errors++;
          $display("FAIL conv_%h: got fixed=%h ovf=%b cyc=%0d, required fixed=%h ovf=%b cyc=%0d",
                   e.op, fixed, ovf, cyc, e.fx, e.ov, e.cy);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] op, input logic [7:0] fx, input logic ov, input int lat);
    exp_t e;
    e.op = op;
    e.fx = fx;
    e.ov = ov;
    e.cy = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic go(input logic [31:0] op, input logic [7:0] fx, input logic ov, input int lat);
    @(negedge clk);
    chk("ready_before_start", 64'(ready), 64'(1));
    start    = 1'b1;
    float_in = op;
    push_exp(op, fx, ov, lat);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    #12;
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_done",  64'(done),  64'(0));
    chk("rst_fixed", 64'(fixed), 64'(0));
    chk("rst_ovf",   64'(ovf),   64'(0));
    @(posedge clk);
    #2 reset = 1'b1;

    // Latency-1 classes.
    go(32'h3FC00000, 8'h01, 1'b0, 1);
    go(32'h43000000, 8'h7F, 1'b1, 1);
    go(32'hC3000000, 8'h80, 1'b0, 1);
    go(32'h7FC00000, 8'h80, 1'b1, 1);
    go(32'h3F000000, 8'h00, 1'b0, 1);
    go(32'h80000000, 8'h00, 1'b0, 1);
    go(32'h7F800000, 8'h7F, 1'b1, 1);
    go(32'hFF800000, 8'h80, 1'b1, 1);
    go(32'hC3008000, 8'h80, 1'b1, 1);
    go(32'h501502F9, 8'h7F, 1'b1, 1);
    go(32'h00000001, 8'h00, 1'b0, 1);
    wait_idle();

    // Iterative path.
    go(32'h40000000, 8'h02, 1'b0, 2);
    wait_idle();
    go(32'hC0700000, 8'hFD, 1'b0, 2);
    wait_idle();
    go(32'h42FE0000, 8'h7F, 1'b0, 7);
    wait_idle();

    go(32'hC2F6E666, 8'h85, 1'b0, 7);
    n = 0;
    for (int i = 0; i < 20 && !ready; i++) begin
      n++;
      @(negedge clk);
    end
    chk("ready_low_cycles", 64'(n), 64'(6));
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_fixed", 64'(fixed), 64'(8'h85));
    chk("hold_ovf",   64'(ovf),   64'(0));

    // Start while busy is ignored; start in the done cycle is accepted.
    go(32'h42C80000, 8'h64, 1'b0, 7);
    start    = 1'b1;
    float_in = 32'h3F800000;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    chk("b2b_done_seen", 64'(done), 64'(1));
    push_exp(32'h3F800000, 8'h01, 1'b0, 1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset in the middle of a conversion.
    @(negedge clk);
    start    = 1'b1;
    float_in = 32'h42C80000;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready), 64'(1));
    chk("midrst_done",  64'(done),  64'(0));
    chk("midrst_fixed", 64'(fixed), 64'(0));
    chk("midrst_ovf",   64'(ovf),   64'(0));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("no_done_after_abort", 64'(n), 64'(0));
    go(32'h42C80000, 8'h64, 1'b0, 7);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iterated_float_to_fixed.md
ITERATED_FLOAT_TO_FIXED -- requirements
Module: iterated_float_to_fixed

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of signed integer result; legal range 2..64.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port start  input  1  request conversion; sampled only while ready=1.
REQ-005 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-006 SHALL have port done  output  1  one-cycle pulse: result and ovf valid.
REQ-007 SHALL have port float  input  32  IEEE-754 single-precision operand, sampled with start.
REQ-008 SHALL have port fixed  output  WIDTH  two's-complement result, truncated toward zero.
REQ-009 SHALL have port ovf  output  1  result saturated or operand NaN/Inf.

Function
REQ-010 SHALL accept start only at an edge where ready=1; start while ready=0 SHALL be ignored.
REQ-011 SHALL capture on acceptance: sign, exponent E, fraction F; unbiased e = E-127.
REQ-012 SHALL classify: ZERO (E<127, includes 0/denormals/|x|<1) -> fixed=0, ovf=0.
REQ-013 SHALL classify: SAT (E=255, or e>WIDTH-1, or e=WIDTH-1 except sign=1 with F=0) -> ovf=1; fixed = 2^(WIDTH-1)-1 if sign=0 and not NaN, else -2^(WIDTH-1).
REQ-014 SHALL classify: EXACT_MIN (e=WIDTH-1, sign=1, F=0) -> fixed=-2^(WIDTH-1), ovf=0.
REQ-015 SHALL classify: NORMAL (0<=e<=WIDTH-2) -> iterative path.
REQ-016 SHALL, for ZERO, SAT, EXACT_MIN and NORMAL with e=0, stay ready=1 and pulse done in the cycle after acceptance (latency 1).
REQ-017 SHALL, for NORMAL e>=1, hold magnitude register M (WIDTH-1 bits, loaded with 1) and fraction shift register (23 bits, loaded with F); deassert ready for exactly e cycles; each cycle M <= {M, MSB of fraction}, fraction <= fraction<<1 with zero fill; down-counter loaded with e.
REQ-018 SHALL pulse done in the cycle after the last shift (latency e+1 from acceptance); ready SHALL return high in that same cycle.
REQ-019 SHALL drive fixed = sign ? -M : M (zero-extended) for NORMAL; negation combinational from held registers.
REQ-020 SHALL hold fixed and ovf stable from done until the next accepted start.
REQ-021 SHALL accept a new start in the same cycle done is high (back-to-back).
REQ-022 SHALL treat -0.0 as ZERO with fixed=0.

Reset
REQ-023 SHALL, while reset=0, force ready=1, done=0, fixed=0, ovf=0, counter/shift registers=0, regardless of clk.
REQ-024 SHALL abort any in-progress conversion on reset; no done pulse for it after release.
REQ-025 SHALL accept start at the first rising edge after reset deassertion.

Structure
REQ-026 SHALL take constants FLOAT_EXP_BIAS=127, FLOAT_EXP_W=8, FLOAT_FRAC_W=23 and packed struct typedef float_fields_t {sign, exponent, fraction} from shared package float_pkg.
REQ-027 SHALL implement classification as combinational logic inside the module; no sub-module required.
REQ-028 SHALL size the counter as $clog2(WIDTH) bits.

Verification (WIDTH=8)
REQ-029 SHALL cover: 0x3FC00000 (1.5) -> fixed=8'h01, ovf=0, done 1 cycle after start.
REQ-030 SHALL cover: 0xC2F6E666 (-123.45) -> ready low 6 cycles, done at cycle 7, fixed=8'h85, ovf=0.
REQ-031 SHALL cover: 0x43000000 (128.0) -> 8'h7F, ovf=1; 0xC3000000 (-128.0) -> 8'h80, ovf=0; 0x7FC00000 (NaN) -> 8'h80, ovf=1; all latency 1.
REQ-032 SHALL cover: 0x3F000000 (0.5) and 0x80000000 (-0.0) -> 8'h00, ovf=0, latency 1.
REQ-033 SHALL cover: start with 0x42C80000 (100.0), second start with 0x3F800000 asserted during busy -> ignored, done once, fixed=8'h64; start again in done cycle -> 8'h01 next cycle.
REQ-034 SHALL cover: reset=0 asserted mid-conversion of 0x42C80000 -> outputs immediately at reset values, no done after release, next start converts normally.
